// File: rtl/if_prefetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : if_prefetch_pkg                                            |
// | Brief   : Shared types and defaults for the if_prefetch fetch unit.  |
// |           FSM state encoding, default widths and counter sizing.     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package if_prefetch_pkg;

  // Fetch control FSM encoding (2 bits)
  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_FLUSH = 2'd2
  } if_state_t;

  localparam int IF_CPU_WIDTH = 32;
  localparam int IF_DEPTH     = 4;
  localparam int IF_PC_STEP   = 4;

  // Counters must hold 0..DEPTH inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_prefetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : if_prefetch_if                                             |
// | Brief   : Bundle of redirect, imem request/response and decode-side  |
// |           handshake signals. master = fetch unit, slave = system.    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface if_prefetch_if
  import if_prefetch_pkg::*;
#(
  parameter int CPU_WIDTH = IF_CPU_WIDTH
);
  logic                 redirect_valid;
  logic [CPU_WIDTH-1:0] redirect_pc;
  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [CPU_WIDTH-1:0] imem_req_addr;
  logic                 imem_rsp_valid;
  logic [CPU_WIDTH-1:0] imem_rsp_data;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [CPU_WIDTH-1:0] inst;
  logic [CPU_WIDTH-1:0] inst_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/if_prefetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : if_prefetch_fifo                                           |
// | Brief   : Synchronous FIFO with clear; push+pop allowed together     |
// |           even when full. DEPTH must be a power of 2, >= 2.          |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module if_prefetch_fifo
  import if_prefetch_pkg::*;
#(
  parameter int WIDTH = 2 * IF_CPU_WIDTH,
  parameter int DEPTH = IF_DEPTH
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  input  wire logic                        push,
  input  wire logic [WIDTH-1:0]            push_data,
  input  wire logic                        pop,
  input  wire logic                        clear,
  output logic [WIDTH-1:0]                 head,
  output logic                             full,
  output logic                             empty,
  output logic [cnt_width(DEPTH)-1:0]      count
);
  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  // Accept a push when there is room or the head leaves in the same cycle
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

  // Storage is not reset; the owner gates the head with empty
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; clear behaves like a local reset
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/if_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : if_prefetch                                                |
// | Brief   : Instruction fetch front end. Issues sequential imem        |
// |           requests, buffers {pc, inst} in a DEPTH-entry FIFO and     |
// |           hands them to decode; flushes on redirect and drops stale  |
// |           in-flight responses.                                       |
// |           Option macro IF_BYPASS_EN: zero-latency rsp->inst path     |
// |           when the FIFO is empty.                                    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int                   CPU_WIDTH = IF_CPU_WIDTH,
  parameter int                   DEPTH     = IF_DEPTH,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0,
  parameter int                   PC_STEP   = IF_PC_STEP
) (
  input wire logic      clk,
  input wire logic      rst_n,
  if_prefetch_if.master bus
);
  localparam int                   W       = CPU_WIDTH;
  localparam int                   CW      = cnt_width(DEPTH);
  localparam logic [CW:0]          DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [W-1:0]         STEP    = W'(PC_STEP);
  localparam logic [W-1:0]         ALIGN_M = ~(W'(3));

  if_state_t      state;
  logic [W-1:0]   fetch_pc;
  logic [W-1:0]   rsp_pc;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  drop_cnt;

  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [2*W-1:0] fifo_head;
  logic           fifo_push;
  logic           fifo_pop;

  logic [W-1:0]   redirect_pc_al;
  logic [CW-1:0]  out_after_rsp;
  logic [CW-1:0]  drop_next;
  logic [CW:0]    in_use;
  logic           req_valid;
  logic           req_fire;
  logic           rsp_keep;
  logic           bypass_hit;
  logic           inst_valid;
  logic [W-1:0]   inst_word;
  logic [W-1:0]   inst_addr;

  // Issue/response/drop decisions for the current cycle
  always_comb begin
    redirect_pc_al = bus.redirect_pc & ALIGN_M;
    out_after_rsp  = (bus.imem_rsp_valid && (outstanding != '0)) ?
                     outstanding - 1'b1 : outstanding;
    in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
    req_valid      = (state == IF_FETCH) && (in_use < DEPTH_W) &&
                     !bus.redirect_valid;
    req_fire       = req_valid && bus.imem_req_ready;
    rsp_keep       = bus.imem_rsp_valid && (drop_cnt == '0) &&
                     !bus.redirect_valid;

    if (bus.redirect_valid) begin
      // everything still in flight after this cycle's response is stale
      drop_next = out_after_rsp;
    end else if (bus.imem_rsp_valid && (drop_cnt != '0)) begin
      drop_next = drop_cnt - 1'b1;
    end else begin
      drop_next = drop_cnt;
    end
  end

  // Decode-side presentation: FIFO head, or the live response when bypassing
  always_comb begin
`ifdef IF_BYPASS_EN
    bypass_hit = rsp_keep && fifo_empty;
`else
    bypass_hit = 1'b0;
`endif
    inst_valid = (!fifo_empty || bypass_hit) && !bus.redirect_valid;
    fifo_pop   = inst_valid && bus.inst_ready && !fifo_empty;
    fifo_push  = rsp_keep && !(bypass_hit && bus.inst_ready) &&
                 (!fifo_full || fifo_pop);
    if (!fifo_empty) begin
      inst_word = fifo_head[W-1:0];
      inst_addr = fifo_head[2*W-1:W];
    end else if (bypass_hit) begin
      inst_word = bus.imem_rsp_data;
      inst_addr = rsp_pc;
    end else begin
      inst_word = '0;
      inst_addr = '0;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst           = inst_word;
  assign bus.inst_pc        = inst_addr;

  // Fetch control FSM with PC, in-flight and drop counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IF_IDLE;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_after_rsp + {{(CW-1){1'b0}}, req_fire};
      drop_cnt    <= drop_next;

      if (bus.redirect_valid) begin
        fetch_pc <= redirect_pc_al;
        rsp_pc   <= redirect_pc_al;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (rsp_keep) rsp_pc   <= rsp_pc + STEP;
      end

      case (state)
        IF_IDLE:  state <= IF_FETCH;
        IF_FETCH: if (bus.redirect_valid && (out_after_rsp != '0)) state <= IF_FLUSH;
        IF_FLUSH: if (drop_next == '0) state <= IF_FETCH;
        default:  state <= IF_IDLE;
      endcase
    end
  end

  if_prefetch_fifo #(
    .WIDTH (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({rsp_pc, bus.imem_rsp_data}),
    .pop       (fifo_pop),
    .clear     (bus.redirect_valid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );
endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_if_prefetch                                             |
// | Brief   : Directed bench for if_prefetch (default build, DEPTH=4):   |
// |           cycle table for streaming/full FIFO, plus stall, flush,    |
// |           same-cycle redirect and mid-stream reset sequences.        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_if_prefetch;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_hold = 1'b0;
  int   fire_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] pend [$];

  if_prefetch_if #(.CPU_WIDTH(W)) bus ();

  if_prefetch #(
    .CPU_WIDTH (W),
    .DEPTH     (4),
    .RESET_PC  (32'h0000_0000),
    .PC_STEP   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word_of(input logic [W-1:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // In-order memory: 1-cycle latency unless held, one response per cycle
  always @(posedge clk) begin
    if (!rst_n) begin
      pend.delete();
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_rsp_data  <= '0;
    end else begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend.push_back(bus.imem_req_addr);
        fire_cnt++;
      end
      if (!mem_hold && pend.size() > 0) begin
        bus.imem_rsp_valid <= 1'b1;
        bus.imem_rsp_data  <= word_of(pend.pop_front());
      end else begin
        bus.imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the negedge, check just after, advance
  task automatic cyc(input string tag, input logic redir, input logic [W-1:0] rpc,
                     input logic rdy, input logic ir,
                     input logic erv, input logic [W-1:0] eaddr,
                     input logic eiv, input logic [W-1:0] epc);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = rdy;
    bus.inst_ready     = ir;
    #1;
    chk({tag, ".req_valid"}, {31'd0, bus.imem_req_valid}, {31'd0, erv});
    if (erv) chk({tag, ".req_addr"}, bus.imem_req_addr, eaddr);
    chk({tag, ".inst_valid"}, {31'd0, bus.inst_valid}, {31'd0, eiv});
    if (eiv) begin
      chk({tag, ".inst_pc"}, bus.inst_pc, epc);
      chk({tag, ".inst"}, bus.inst, word_of(epc));
    end
    @(negedge clk);
  endtask

  // Two reset edges, check the reset outputs, release at a negedge
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, ".rst_req_valid"}, {31'd0, bus.imem_req_valid}, 32'd0);
    chk({tag, ".rst_inst_valid"}, {31'd0, bus.inst_valid}, 32'd0);
    chk({tag, ".rst_inst"}, bus.inst, 32'd0);
    chk({tag, ".rst_inst_pc"}, bus.inst_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic         rdy;
    logic         ir;
    logic         erv;
    logic [W-1:0] eaddr;
    logic         eiv;
    logic [W-1:0] epc;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int f0;
    // streaming with decode ready, then decode stalls until the FIFO fills
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h18};

    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;

    do_reset("tbl");
    for (int i = 0; i < 14; i++) begin
      cyc($sformatf("tbl%0d", i), 1'b0, 32'h0, vecs[i].rdy, vecs[i].ir,
          vecs[i].erv, vecs[i].eaddr, vecs[i].eiv, vecs[i].epc);
    end

    // request held for 3 cycles with ready low: address stable, no duplicates
    do_reset("stall");
    f0 = fire_cnt;
    cyc("stall0", 0, 0, 0, 1, 0, 32'h00, 0, 32'h00);
    cyc("stall1", 0, 0, 0, 1, 1, 32'h00, 0, 32'h00);
    cyc("stall2", 0, 0, 0, 1, 1, 32'h00, 0, 32'h00);
    cyc("stall3", 0, 0, 0, 1, 1, 32'h00, 0, 32'h00);
    cyc("stall4", 0, 0, 1, 1, 1, 32'h00, 0, 32'h00);
    cyc("stall5", 0, 0, 1, 1, 1, 32'h04, 0, 32'h00);
    cyc("stall6", 0, 0, 1, 1, 1, 32'h08, 1, 32'h00);
    cyc("stall7", 0, 0, 1, 1, 1, 32'h0C, 1, 32'h04);
    chk("stall.fires", 32'(fire_cnt - f0), 32'd4);

    // redirect with 0x8/0xC in flight: flush drops both, restart at 0x100
    do_reset("flush");
    mem_hold = 1'b1;
    cyc("flush0", 0, 0, 1, 1, 0, 32'h00, 0, 32'h00);
    cyc("flush1", 0, 0, 1, 1, 1, 32'h00, 0, 32'h00);
    cyc("flush2", 0, 0, 1, 1, 1, 32'h04, 0, 32'h00);
    cyc("flush3", 0, 0, 1, 1, 1, 32'h08, 0, 32'h00);
    cyc("flush4", 0, 0, 1, 1, 1, 32'h0C, 0, 32'h00);
    mem_hold = 1'b0;
    cyc("flush5", 0, 0, 1, 1, 0, 32'h00, 0, 32'h00);
    cyc("flush6", 0, 0, 1, 1, 0, 32'h00, 0, 32'h00);
    mem_hold = 1'b1;
    cyc("flush7", 0, 0, 1, 1, 0, 32'h00, 1, 32'h00);
    cyc("flush8", 1, 32'h100, 1, 1, 0, 32'h00, 0, 32'h00);
    mem_hold = 1'b0;
    cyc("flush9", 0, 0, 1, 1, 0, 32'h00, 0, 32'h00);
    cyc("flush10", 0, 0, 1, 1, 0, 32'h00, 0, 32'h00);
    cyc("flush11", 0, 0, 1, 1, 0, 32'h00, 0, 32'h00);
    cyc("flush12", 0, 0, 1, 1, 1, 32'h100, 0, 32'h00);
    cyc("flush13", 0, 0, 1, 1, 1, 32'h104, 0, 32'h00);
    cyc("flush14", 0, 0, 1, 1, 1, 32'h108, 1, 32'h100);

    // redirect to unaligned 0x103 while response 0xC arrives
    do_reset("redir");
    cyc("redir0", 0, 0, 1, 1, 0, 32'h00, 0, 32'h00);
    cyc("redir1", 0, 0, 1, 1, 1, 32'h00, 0, 32'h00);
    cyc("redir2", 0, 0, 1, 1, 1, 32'h04, 0, 32'h00);
    cyc("redir3", 0, 0, 1, 1, 1, 32'h08, 1, 32'h00);
    cyc("redir4", 0, 0, 1, 1, 1, 32'h0C, 1, 32'h04);
    cyc("redir5", 1, 32'h103, 1, 1, 0, 32'h00, 0, 32'h00);
    cyc("redir6", 0, 0, 1, 1, 1, 32'h100, 0, 32'h00);
    cyc("redir7", 0, 0, 1, 1, 1, 32'h104, 0, 32'h00);
    cyc("redir8", 0, 0, 1, 1, 1, 32'h108, 1, 32'h100);
    cyc("redir9", 0, 0, 1, 1, 1, 32'h10C, 1, 32'h104);

    // reset mid-stream: outputs cleared, fetch restarts at RESET_PC
    do_reset("midrst");
    cyc("midrst0", 0, 0, 1, 1, 0, 32'h00, 0, 32'h00);
    cyc("midrst1", 0, 0, 1, 1, 1, 32'h00, 0, 32'h00);
    cyc("midrst2", 0, 0, 1, 1, 1, 32'h04, 0, 32'h00);
    cyc("midrst3", 0, 0, 1, 1, 1, 32'h08, 1, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
